uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two byte producers: requester 0 (core MMIO write path to the UART TX data register) and requester 1 (RX echo / debug monitor). It sits between the producers and the transmitter's `tx_data` / `tx_data_valid` / `tx_data_ready` handshake. It holds one byte in an output register and grants round-robin. An optional line-lock keeps text lines from interleaving on the serial link.

---
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte producers.
// Requester 0 is the core MMIO TX path and requester 1 is the RX echo/debug
// monitor. One byte is held in a registered output stage and ownership
// alternates round-robin at each transmitter handoff.
// Optional line-lock (define UART_TX_ARB_LINE_LOCK_EN): a requester that starts
// a text line keeps the transmitter until it sends EOL_CHAR or stays idle for
// LOCK_TIMEOUT cycles, so lines from the two producers never interleave.
module uart_tx_arbiter #(
    parameter int          LOCK_TIMEOUT = 27000,
    parameter logic [7:0]  EOL_CHAR     = 8'h0A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_data_ready,
    output logic [1:0] grant,
    output logic       busy
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t     state, next_state;
    logic       prio;
    logic       win_valid;
    logic       win_id;
    logic [7:0] win_data;
    logic       accept;
    logic       handoff;

`ifdef UART_TX_ARB_LINE_LOCK_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);

    logic          lock_held;
    logic          lock_owner;
    logic          owner_valid;
    logic          count_en;
    logic          timeout_hit;
    logic [CW-1:0] lock_cnt;

    assign owner_valid = lock_owner ? req1_valid : req0_valid;
    assign count_en    = (state == IDLE) && lock_held && !owner_valid;
    assign timeout_hit = count_en && (lock_cnt == CNT_LAST);
`endif

    // Pick the winner among valid requesters; a held lock restricts it to the owner
    always_comb begin
        win_valid = 1'b0;
        win_id    = 1'b0;
`ifdef UART_TX_ARB_LINE_LOCK_EN
        if (lock_held) begin
            win_valid = owner_valid;
            win_id    = lock_owner;
        end else
`endif
        if (req0_valid && req1_valid) begin
            win_valid = 1'b1;
            win_id    = prio;
        end else if (req0_valid) begin
            win_valid = 1'b1;
            win_id    = 1'b0;
        end else if (req1_valid) begin
            win_valid = 1'b1;
            win_id    = 1'b1;
        end
        win_data = win_id ? req1_data : req0_data;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: accept a byte in IDLE, wait for the transmitter in SEND
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        handoff    = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    accept     = 1'b1;
                    next_state = SEND;
                end
            end
            SEND: begin
                if (tx_data_valid && tx_data_ready) begin
                    handoff    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign req0_ready = accept && !win_id;
    assign req1_ready = accept &&  win_id;
    assign busy       = (state == SEND);

    // Output byte register; tx_data deliberately keeps its value after handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            grant         <= 2'b00;
        end else if (accept) begin
            tx_data       <= win_data;
            tx_data_valid <= 1'b1;
            grant         <= win_id ? 2'b10 : 2'b01;
        end else if (handoff) begin
            tx_data_valid <= 1'b0;
            grant         <= 2'b00;
        end
    end

`ifdef UART_TX_ARB_LINE_LOCK_EN
    // Priority moves to the other requester on unlocked handoffs, on the EOL that ends a line, or on lock timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (handoff) begin
            if (!lock_held || (tx_data == EOL_CHAR && lock_owner == grant[1]))
                prio <= ~grant[1];
        end else if (timeout_hit) begin
            prio <= ~lock_owner;
        end
    end

    // Line-lock: set by any non-EOL byte, cleared by the owner's EOL handoff or by timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_held  <= 1'b0;
            lock_owner <= 1'b0;
        end else if (accept && win_data != EOL_CHAR) begin
            lock_held  <= 1'b1;
            lock_owner <= win_id;
        end else if (handoff && lock_held && tx_data == EOL_CHAR) begin
            lock_held  <= 1'b0;
        end else if (timeout_hit) begin
            lock_held  <= 1'b0;
        end
    end

    // Idle counter: runs only while the owner is silent in IDLE with the lock held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           lock_cnt <= '0;
        else if (timeout_hit) lock_cnt <= '0;
        else if (count_en)    lock_cnt <= lock_cnt + CW'(1);
        else                  lock_cnt <= '0;
    end
`else
    // Plain per-byte round-robin: the requester just served drops to low priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       prio <= 1'b0;
        else if (handoff) prio <= ~grant[1];
    end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Expected bytes and owners are queued by the
// stimulus process; a monitor pops one entry per transmitter handoff.
// Line-lock scenarios run when UART_TX_ARB_LINE_LOCK_EN is defined.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] tx_data;
    logic       tx_data_valid, tx_data_ready;
    logic [1:0] grant;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        logic [1:0] grant;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   leak1;
    int   bad;
    int   n;
    logic found;

    uart_tx_arbiter #(.LOCK_TIMEOUT(16), .EOL_CHAR(8'h0A)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req0_data     (req0_data),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req1_data     (req1_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant         (grant),
        .busy          (busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [7:0] d1, input logic txr);
        req0_valid    = v0;
        req0_data     = d0;
        req1_valid    = v1;
        req1_data     = d1;
        tx_data_ready = txr;
    endtask

    task automatic pushExp(input logic [7:0] d, input logic [1:0] g);
        exp_t e;
        e.data  = d;
        e.grant = g;
        sb_q.push_back(e);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Requester 0 offers one byte and holds it until accepted; counts any req1 grant meanwhile
    task automatic sendByte0(input logic [7:0] d);
        logic ok;
        ok = 1'b0;
        req0_data  = d;
        req0_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req1_ready) leak1++;
            if (req0_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("send0_accepted", {31'b0, ok}, 32'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
    endtask

    // Monitor: every handoff must match the next queued byte and owner
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tx_data_valid && tx_data_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_underflow", sb_q.size(), 32'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("tx_data", {24'b0, tx_data}, {24'b0, e.data});
                checkOutput("tx_grant", {30'b0, grant}, {30'b0, e.grant});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus
    initial begin
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        rst_n = 1'b0;
        #12;
        checkOutput("rst_tx_data", {24'b0, tx_data}, 32'h00);
        checkOutput("rst_valid", {31'b0, tx_data_valid}, 32'd0);
        checkOutput("rst_grant", {30'b0, grant}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_ready0", {31'b0, req0_ready}, 32'd0);
        checkOutput("idle_ready1", {31'b0, req1_ready}, 32'd0);

        // Single byte from requester 0 with transmitter ready
        @(posedge clk);
        #1 applyStimulus(1'b1, 8'h30, 1'b0, 8'h00, 1'b1);
        pushExp(8'h30, 2'b01);
        @(negedge clk);
        checkOutput("t1_ready0", {31'b0, req0_ready}, 32'd1);
        checkOutput("t1_ready1", {31'b0, req1_ready}, 32'd0);
        @(posedge clk);
        #1 applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("t1_tx_data", {24'b0, tx_data}, 32'h30);
        checkOutput("t1_valid", {31'b0, tx_data_valid}, 32'd1);
        checkOutput("t1_grant", {30'b0, grant}, 32'd1);
        checkOutput("t1_busy", {31'b0, busy}, 32'd1);
        checkOutput("t1_send_ready0", {31'b0, req0_ready}, 32'd0);
        @(negedge clk);
        checkOutput("t1_idle_valid", {31'b0, tx_data_valid}, 32'd0);
        checkOutput("t1_idle_grant", {30'b0, grant}, 32'd0);
        checkOutput("t1_idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("t1_hold_data", {24'b0, tx_data}, 32'h30);

`ifndef UART_TX_ARB_LINE_LOCK_EN
        // Round-robin with both requesters streaming
        doReset();
        applyStimulus(1'b1, 8'h41, 1'b1, 8'h42, 1'b1);
        for (int i = 0; i < 4; i++) begin
            pushExp(8'h41, 2'b01);
            pushExp(8'h42, 2'b10);
        end
        @(negedge clk);
        checkOutput("rr_first_ready0", {31'b0, req0_ready}, 32'd1);
        checkOutput("rr_first_ready1", {31'b0, req1_ready}, 32'd0);
        repeat (16) @(posedge clk);
        #1 applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (2) @(posedge clk);
`else
        // Line-lock: req0 owns the link until its EOL is handed off
        doReset();
        leak1 = 0;
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h42, 1'b1);
        pushExp(8'h30, 2'b01);
        pushExp(8'h31, 2'b01);
        pushExp(8'h0D, 2'b01);
        pushExp(8'h0A, 2'b01);
        pushExp(8'h42, 2'b10);
        sendByte0(8'h30);
        sendByte0(8'h31);
        sendByte0(8'h0D);
        sendByte0(8'h0A);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (req1_ready) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("lock_no_leak", leak1, 32'd0);
        checkOutput("lock_req1_seen", {31'b0, found}, 32'd1);
        checkOutput("lock_release_lat", n, 32'd2);
        @(posedge clk);
        #1 applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (3) @(posedge clk);

        // Line-lock timeout after 16 silent IDLE cycles
        doReset();
        applyStimulus(1'b1, 8'h30, 1'b1, 8'h42, 1'b1);
        pushExp(8'h30, 2'b01);
        pushExp(8'h42, 2'b10);
        @(negedge clk);
        checkOutput("to_first_ready0", {31'b0, req0_ready}, 32'd1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(posedge clk);
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req1_ready) begin
                found = 1'b1;
                break;
            end
            n++;
        end
        checkOutput("to_req1_seen", {31'b0, found}, 32'd1);
        checkOutput("to_wait_cycles", n, 32'd16);
        @(posedge clk);
        #1 applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (3) @(posedge clk);
`endif

        // Backpressure: byte held for 500 cycles while the transmitter stalls
        doReset();
        applyStimulus(1'b1, 8'h55, 1'b1, 8'h99, 1'b0);
        pushExp(8'h55, 2'b01);
        @(negedge clk);
        checkOutput("bp_ready0", {31'b0, req0_ready}, 32'd1);
        checkOutput("bp_ready1", {31'b0, req1_ready}, 32'd0);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx_data !== 8'h55 || tx_data_valid !== 1'b1 || req0_ready !== 1'b0 ||
                req1_ready !== 1'b0 || busy !== 1'b1 || grant !== 2'b01)
                bad++;
        end
        checkOutput("bp_stable", bad, 32'd0);
        @(posedge clk);
        #1 applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("bp_still_valid", {31'b0, tx_data_valid}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp_handoff_valid", {31'b0, tx_data_valid}, 32'd0);
        checkOutput("bp_handoff_busy", {31'b0, busy}, 32'd0);

        // Asynchronous reset in the middle of SEND
        doReset();
        applyStimulus(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        checkOutput("ar_pre_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", {31'b0, tx_data_valid}, 32'd0);
        checkOutput("ar_grant", {30'b0, grant}, 32'd0);
        checkOutput("ar_busy", {31'b0, busy}, 32'd0);
        checkOutput("ar_tx_data", {24'b0, tx_data}, 32'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(1'b1, 8'h61, 1'b1, 8'h62, 1'b1);
        pushExp(8'h61, 2'b01);
        @(negedge clk);
        checkOutput("ar_after_ready0", {31'b0, req0_ready}, 32'd1);
        checkOutput("ar_after_ready1", {31'b0, req1_ready}, 32'd0);
        @(posedge clk);
        #1 applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (3) @(posedge clk);

        checkOutput("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
